// File: rtl/cbfp_denorm.sv
`timescale 1ns/1ps
// cbfp_denorm
// Undoes the CBFP normalisation at the FFT output. It takes 16 complex
// mantissas per cycle and rescales each lane by its own CBFP index. The
// result is a wide, saturated two's-complement value. The module also emits
// a per-cycle saturation flag and a marker on the last cycle of each block.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   di_re/di_im  16 signed mantissas per component (IWIDTH bits)
//   di_index     16 unsigned CBFP indices (5 bits)
//   di_en        input valid
//   do_re/do_im  16 restored values per component (OWIDTH bits), held while idle
//   do_en        output valid, two cycles after di_en
//   do_blk_last  last cycle of a complete BLK_CYC-cycle block
//   do_sat       some lane/component clipped on this output cycle
module cbfp_denorm #(
  parameter int IWIDTH    = 11,
  parameter int OWIDTH    = 23,
  parameter int BIAS      = 12,
  parameter int IDX_LIMIT = 16,
  parameter int BLK_CYC   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [IWIDTH-1:0] di_re    [16],
  input  logic signed [IWIDTH-1:0] di_im    [16],
  input  logic        [4:0]        di_index [16],
  input  logic                     di_en,
  output logic signed [OWIDTH-1:0] do_re    [16],
  output logic signed [OWIDTH-1:0] do_im    [16],
  output logic                     do_en,
  output logic                     do_blk_last,
  output logic                     do_sat
);

  localparam int LANES  = 16;
  localparam int MAX_SH = (BIAS > IDX_LIMIT - BIAS) ? BIAS : IDX_LIMIT - BIAS;
  localparam int SHW    = (MAX_SH < 2) ? 1 : $clog2(MAX_SH + 1);
  // The extended width leaves room for a full BIAS-bit left shift, so
  // overflow is only detected by the saturation compare and never wraps.
  localparam int EW     = OWIDTH + BIAS;
  localparam int CW     = (BLK_CYC < 2) ? 1 : $clog2(BLK_CYC);

  localparam logic signed [EW-1:0] SAT_MAX = {{(BIAS + 1){1'b0}}, {(OWIDTH - 1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(BIAS + 1){1'b1}}, {(OWIDTH - 1){1'b0}}};

  // Clamp the index, then split it into a direction (1 = right) and a
  // shift amount. The direction bit is in the MSB of the return value.
  function automatic logic [SHW:0] decode_idx(input logic [4:0] idx);
    int c;
    c = (int'(idx) > IDX_LIMIT) ? IDX_LIMIT : int'(idx);
    if (c >= BIAS) return {1'b1, SHW'(c - BIAS)};
    else           return {1'b0, SHW'(BIAS - c)};
  endfunction

  // Scale one mantissa and clip it to OWIDTH. The saturation flag is in the
  // MSB of the return value. A right shift is arithmetic, so it truncates
  // toward -inf.
  function automatic logic [OWIDTH:0] restore(input logic signed [IWIDTH-1:0] m,
                                              input logic dir,
                                              input logic [SHW-1:0] sh);
    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] sft;
    ext = {{(EW - IWIDTH){m[IWIDTH-1]}}, m};
    sft = dir ? (ext >>> sh) : (ext <<< sh);
    if (sft > SAT_MAX)      return {1'b1, SAT_MAX[OWIDTH-1:0]};
    else if (sft < SAT_MIN) return {1'b1, SAT_MIN[OWIDTH-1:0]};
    else                    return {1'b0, sft[OWIDTH-1:0]};
  endfunction

  logic [CW-1:0]            blk_cnt;
  logic                     s1_en;
  logic                     s1_last;
  logic signed [IWIDTH-1:0] s1_re  [LANES];
  logic signed [IWIDTH-1:0] s1_im  [LANES];
  logic                     s1_dir [LANES];
  logic [SHW-1:0]           s1_sh  [LANES];
  logic [SHW:0]             dec    [LANES];
  logic [OWIDTH:0]          res_re [LANES];
  logic [OWIDTH:0]          res_im [LANES];
  logic                     any_sat;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      dec[i] = decode_idx(di_index[i]);
    end
  end

  // Stage 1 holds the block counter. Any idle cycle aborts a partial block,
  // so the counter restarts at 0 on the next valid cycle. The last-of-block
  // flag is captured alongside the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt <= '0;
      s1_en   <= 1'b0;
      s1_last <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_re[i]  <= '0;
        s1_im[i]  <= '0;
        s1_dir[i] <= 1'b0;
        s1_sh[i]  <= '0;
      end
    end else begin
      s1_en   <= di_en;
      s1_last <= di_en && (blk_cnt == CW'(BLK_CYC - 1));
      if (di_en) begin
        blk_cnt <= (blk_cnt == CW'(BLK_CYC - 1)) ? '0 : blk_cnt + CW'(1);
        for (int i = 0; i < LANES; i++) begin
          s1_re[i]  <= di_re[i];
          s1_im[i]  <= di_im[i];
          s1_dir[i] <= dec[i][SHW];
          s1_sh[i]  <= dec[i][SHW-1:0];
        end
      end else begin
        blk_cnt <= '0;
      end
    end
  end

  // Rescale and saturate all 32 components. The clip flags are ORed into a
  // single per-cycle indicator.
  always_comb begin
    any_sat = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      res_re[i] = restore(s1_re[i], s1_dir[i], s1_sh[i]);
      res_im[i] = restore(s1_im[i], s1_dir[i], s1_sh[i]);
      any_sat   = any_sat | res_re[i][OWIDTH] | res_im[i][OWIDTH];
    end
  end

  // Stage 2 registers the outputs. The data holds while idle, and the flags
  // are qualified by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      do_en       <= 1'b0;
      do_blk_last <= 1'b0;
      do_sat      <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        do_re[i] <= '0;
        do_im[i] <= '0;
      end
    end else begin
      do_en       <= s1_en;
      do_blk_last <= s1_en & s1_last;
      do_sat      <= s1_en & any_sat;
      if (s1_en) begin
        for (int i = 0; i < LANES; i++) begin
          do_re[i] <= res_re[i][OWIDTH-1:0];
          do_im[i] <= res_im[i][OWIDTH-1:0];
        end
      end
    end
  end

endmodule
